// File: rtl/bcd_pkg.sv
// ============================================================================
//  Module      : bcd_pkg
//  Description : Shared states, digit constants and BCD helpers for the
//                two-digit BCD countdown timer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

   localparam int DIGIT_W = 4;
   localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   // True when both nibbles of a two-digit value are legal decimal digits.
   function automatic logic bcd_valid(input logic [2*DIGIT_W-1:0] v);
      return (v[2*DIGIT_W-1:DIGIT_W] <= BCD_MAX) && (v[DIGIT_W-1:0] <= BCD_MAX);
   endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_dec.sv
// ============================================================================
//  Module      : bcd_digit_dec
//  Description : Single BCD digit decrementer with borrow chaining.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit_dec
   import bcd_pkg::*;
(
   input  logic [DIGIT_W-1:0] digit_i,
   input  logic               borrow_i,
   output logic [DIGIT_W-1:0] digit_o,
   output logic               borrow_o
);

   // A borrow into a zero digit wraps it to nine and propagates upward.
   always_comb begin
      digit_o  = digit_i;
      borrow_o = 1'b0;
      if (borrow_i) begin
         if (digit_i == '0) begin
            digit_o  = BCD_MAX;
            borrow_o = 1'b1;
         end else begin
            digit_o  = digit_i - DIGIT_W'(1);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/bcd_countdown.sv
// ============================================================================
//  Module      : bcd_countdown
//  Description : Two-digit BCD countdown timer with load/start/pause control,
//                sticky invalid-preset flag and optional auto-reload.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_countdown
   import bcd_pkg::*;
#(
   parameter bit AUTO_RELOAD = 1'b0
)
(
   input  logic                 clk_1Hz,
   input  logic                 reset,
   input  logic                 load,
   input  logic [2*DIGIT_W-1:0] preset,
   input  logic                 start,
   input  logic                 pause,
   output logic [2*DIGIT_W-1:0] count,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);

   state_t               state_q,  state_d;
   logic [2*DIGIT_W-1:0] count_q,  count_d;
   logic [2*DIGIT_W-1:0] reload_q, reload_d;
   logic                 err_q,    err_d;
   logic                 done_q,   done_d;
   logic                 busy_q;

   logic [DIGIT_W-1:0]   ones_dec, tens_dec;
   logic                 ones_borrow, tens_borrow;
   logic [2*DIGIT_W-1:0] dec_cnt;
   logic                 at_zero;
   logic                 run_step;

   bcd_digit_dec u_ones (
      .digit_i  (count_q[DIGIT_W-1:0]),
      .borrow_i (1'b1),
      .digit_o  (ones_dec),
      .borrow_o (ones_borrow)
   );

   bcd_digit_dec u_tens (
      .digit_i  (count_q[2*DIGIT_W-1:DIGIT_W]),
      .borrow_i (ones_borrow),
      .digit_o  (tens_dec),
      .borrow_o (tens_borrow)
   );

   // A borrow out of the tens digit happens only when the count is 00.
   assign at_zero = tens_borrow;
   assign dec_cnt = {tens_dec, ones_dec};

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      err_d    = err_q;
      done_d   = 1'b0;
      run_step = 1'b0;

      if (load) begin
         if (bcd_valid(preset)) begin
            count_d  = preset;
            reload_d = preset;
            err_d    = 1'b0;
            state_d  = IDLE;
         end else begin
            err_d    = 1'b1;
         end
      end else begin
         case (state_q)
            IDLE:    run_step = !pause && start && !at_zero;
            RUN:     if (pause) state_d = PAUSE;
                     else       run_step = 1'b1;
            PAUSE:   if (!pause && start) state_d = RUN;
            default: state_d = state_q;
         endcase
      end

      // One countdown step; sitting at 00 only happens with auto-reload.
      if (run_step) begin
         if (at_zero) begin
            state_d = (AUTO_RELOAD && (reload_q != '0)) ? RUN : DONE;
            if (AUTO_RELOAD) count_d = reload_q;
         end else begin
            count_d = dec_cnt;
            state_d = RUN;
            if (dec_cnt == '0) begin
               done_d = 1'b1;
               if (!AUTO_RELOAD) state_d = DONE;
            end
         end
      end
   end

   always_ff @(posedge clk_1Hz or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         count_q  <= '0;
         reload_q <= '0;
         err_q    <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         err_q    <= err_d;
         done_q   <= done_d;
         busy_q   <= (state_d == RUN);
      end
   end

   assign count = count_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign err   = err_q;

endmodule

`default_nettype wire
